// File: rtl/fsk_seq_pkg.sv
// rtl/fsk_seq_pkg.sv - shared types and constants for the FSK symbol sequencer
package fsk_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    localparam int FCW_W          = 30;
    localparam int STOP_CYCLES    = 2;
    localparam int ACTIVE_TIMEOUT = 4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with level output
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   flush               empties the FIFO (wins over a coincident push/pop)
//   push, push_data     write request; ignored while full
//   pop, pop_data       read request; pop_data shows the head entry combinationally
//   full, empty, level  occupancy status
module sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full     = (level_q == (AW+1)'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/fsk_symbol_sequencer.sv
// rtl/fsk_symbol_sequencer.sv - M-FSK symbol FIFO, tone table and transmit lifecycle FSM
// Macro FSK_SEQ_IDLE_TONE_EN: when defined, an empty FIFO at a symbol boundary keeps
// transmitting tone 0 instead of shutting the generator down.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   cfg_tone_we/idx/fcw              tone table write port
//   cfg_sym_len                      clocks per symbol (0 behaves as 1)
//   sym_valid, sym_data, sym_ready   symbol push interface
//   tx_go, tx_stop                   start / abort pulses
//   gen_active                       generator running indication
//   f_c, gen_start, gen_reset_n      generator controls
//   busy, underrun, fifo_level       status
module fsk_symbol_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int SYM_W      = 2,
    parameter int FCW_W      = fsk_seq_pkg::FCW_W,
    parameter int DUR_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_tone_we,
    input  logic [SYM_W-1:0]              cfg_tone_idx,
    input  logic [FCW_W-1:0]              cfg_tone_fcw,
    input  logic [DUR_W-1:0]              cfg_sym_len,
    input  logic                          sym_valid,
    input  logic [SYM_W-1:0]              sym_data,
    output logic                          sym_ready,
    input  logic                          tx_go,
    input  logic                          tx_stop,
    input  logic                          gen_active,
    output logic [FCW_W-1:0]              f_c,
    output logic                          gen_start,
    output logic                          gen_reset_n,
    output logic                          busy,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import fsk_seq_pkg::*;

    localparam int TONES  = 2**SYM_W;
    localparam int ACT_W  = $clog2(ACTIVE_TIMEOUT + 1);
    localparam int STOP_W = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [DUR_W-1:0]   cnt_q, cnt_d;
    logic [FCW_W-1:0]   f_c_q, f_c_d;
    logic               gen_start_q, gen_start_d;
    logic               gen_reset_n_q, gen_reset_n_d;
    logic               busy_q, busy_d;
    logic               underrun_q, underrun_d;
    logic [STOP_W-1:0]  stop_cnt_q, stop_cnt_d;
    logic [ACT_W-1:0]   act_cnt_q, act_cnt_d;
    logic [FCW_W-1:0]   tone_q [TONES];
    logic [FCW_W-1:0]   tone_d [TONES];

    logic               fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [SYM_W-1:0]   fifo_head;
    logic [DUR_W-1:0]   sym_len_eff;

    sync_fifo #(
        .WIDTH (SYM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (sym_valid),
        .push_data (sym_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign sym_ready   = !fifo_full;
    assign sym_len_eff = (cfg_sym_len == '0) ? DUR_W'(1) : cfg_sym_len;

    assign f_c         = f_c_q;
    assign gen_start   = gen_start_q;
    assign gen_reset_n = gen_reset_n_q;
    assign busy        = busy_q;
    assign underrun    = underrun_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        f_c_d      = f_c_q;
        gen_start_d = 1'b0;
        underrun_d = underrun_q;
        stop_cnt_d = stop_cnt_q;
        act_cnt_d  = act_cnt_q;
        tone_d     = tone_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        if (cfg_tone_we) begin
            tone_d[cfg_tone_idx] = cfg_tone_fcw;
        end

        case (state_q)
            IDLE: begin
                if (tx_go && !fifo_empty) begin
                    fifo_pop    = 1'b1;
                    f_c_d       = tone_q[fifo_head];
                    cnt_d       = sym_len_eff;
                    gen_start_d = 1'b1;
                    underrun_d  = 1'b0;
                    act_cnt_d   = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q - DUR_W'(1);
                // Saturating count of cycles since gen_start; arms the fault check.
                if (act_cnt_q < ACT_W'(ACTIVE_TIMEOUT)) begin
                    act_cnt_d = act_cnt_q + ACT_W'(1);
                end
                if (tx_stop) begin
                    fifo_flush = 1'b1;
                    f_c_d      = '0;
                    stop_cnt_d = '0;
                    state_d    = STOP;
                end else if (act_cnt_q >= ACT_W'(ACTIVE_TIMEOUT) && !gen_active) begin
                    underrun_d = 1'b1;
                    f_c_d      = '0;
                    stop_cnt_d = '0;
                    state_d    = STOP;
                end else if (cnt_q == DUR_W'(1)) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        f_c_d    = tone_q[fifo_head];
                        cnt_d    = sym_len_eff;
                    end else begin
                        underrun_d = 1'b1;
`ifdef FSK_SEQ_IDLE_TONE_EN
                        f_c_d = tone_q[0];
                        cnt_d = sym_len_eff;
`else
                        f_c_d      = '0;
                        stop_cnt_d = '0;
                        state_d    = STOP;
`endif
                    end
                end
            end
            STOP: begin
                if (stop_cnt_q == STOP_W'(STOP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    stop_cnt_d = stop_cnt_q + STOP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        busy_d        = (state_d != IDLE);
        gen_reset_n_d = (state_d != STOP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            f_c_q         <= '0;
            gen_start_q   <= 1'b0;
            gen_reset_n_q <= 1'b0;
            busy_q        <= 1'b0;
            underrun_q    <= 1'b0;
            stop_cnt_q    <= '0;
            act_cnt_q     <= '0;
            for (int i = 0; i < TONES; i++) begin
                tone_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            f_c_q         <= f_c_d;
            gen_start_q   <= gen_start_d;
            gen_reset_n_q <= gen_reset_n_d;
            busy_q        <= busy_d;
            underrun_q    <= underrun_d;
            stop_cnt_q    <= stop_cnt_d;
            act_cnt_q     <= act_cnt_d;
            tone_q        <= tone_d;
        end
    end

endmodule

// File: tb/tb_fsk_symbol_sequencer.sv
// tb/tb_fsk_symbol_sequencer.sv - directed self-checking bench for fsk_symbol_sequencer
module tb_fsk_symbol_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_tone_we;
    logic [1:0]  cfg_tone_idx;
    logic [29:0] cfg_tone_fcw;
    logic [15:0] cfg_sym_len;
    logic        sym_valid;
    logic [1:0]  sym_data;
    logic        sym_ready;
    logic        tx_go;
    logic        tx_stop;
    logic        gen_active;
    logic [29:0] f_c;
    logic        gen_start;
    logic        gen_reset_n;
    logic        busy;
    logic        underrun;
    logic [3:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fsk_symbol_sequencer #(
        .FIFO_DEPTH (8),
        .SYM_W      (2),
        .FCW_W      (30),
        .DUR_W      (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_tone_we  (cfg_tone_we),
        .cfg_tone_idx (cfg_tone_idx),
        .cfg_tone_fcw (cfg_tone_fcw),
        .cfg_sym_len  (cfg_sym_len),
        .sym_valid    (sym_valid),
        .sym_data     (sym_data),
        .sym_ready    (sym_ready),
        .tx_go        (tx_go),
        .tx_stop      (tx_stop),
        .gen_active   (gen_active),
        .f_c          (f_c),
        .gen_start    (gen_start),
        .gen_reset_n  (gen_reset_n),
        .busy         (busy),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    typedef struct {
        logic        push;
        logic [1:0]  sym;
        logic        go;
        logic        stop;
        logic [29:0] fc;
        logic        start;
        logic        rstn;
        logic        bsy;
        logic        urun;
        logic [3:0]  lvl;
    } vec_t;

    vec_t vt [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic push, input logic [1:0] sym, input logic go, input logic stop);
        @(negedge clk);
        sym_valid   = push;
        sym_data    = sym;
        tx_go       = go;
        tx_stop     = stop;
        cfg_tone_we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic write_tone(input logic [1:0] idx, input logic [29:0] fcw);
        @(negedge clk);
        sym_valid    = 1'b0;
        tx_go        = 1'b0;
        tx_stop      = 1'b0;
        cfg_tone_we  = 1'b1;
        cfg_tone_idx = idx;
        cfg_tone_fcw = fcw;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " f_c"},         32'(f_c),         32'(0));
        check({tag, " gen_start"},   32'(gen_start),   32'(0));
        check({tag, " gen_reset_n"}, 32'(gen_reset_n), 32'(0));
        check({tag, " busy"},        32'(busy),        32'(0));
        check({tag, " underrun"},    32'(underrun),    32'(0));
        check({tag, " fifo_level"},  32'(fifo_level),  32'(0));
        check({tag, " sym_ready"},   32'(sym_ready),   32'(1));
    endtask

    task automatic to_idle();
        if (busy) step(1'b0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8 && busy; i++) step(1'b0, 2'd0, 1'b0, 1'b0);
        check("to_idle busy", 32'(busy), 32'(0));
    endtask

    initial begin
        int n;
        reset        = 1'b1;
        cfg_tone_we  = 1'b0;
        cfg_tone_idx = 2'd0;
        cfg_tone_fcw = 30'h0;
        cfg_sym_len  = 16'd5;
        sym_valid    = 1'b0;
        sym_data     = 2'd0;
        tx_go        = 1'b0;
        tx_stop      = 1'b0;
        gen_active   = 1'b1;

        // Test 1 vectors: push 2,0 then go with len=5
        vt[0] = '{1'b1, 2'd2, 1'b0, 1'b0, 30'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
        vt[1] = '{1'b1, 2'd0, 1'b0, 1'b0, 30'h000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};
        vt[2] = '{1'b0, 2'd0, 1'b1, 1'b0, 30'h300, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1};
        for (int i = 3; i <= 6; i++)
            vt[i] = '{1'b0, 2'd0, 1'b0, 1'b0, 30'h300, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
        for (int i = 7; i <= 11; i++)
            vt[i] = '{1'b0, 2'd0, 1'b0, 1'b0, 30'h100, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
`ifdef FSK_SEQ_IDLE_TONE_EN
        for (int i = 12; i <= 14; i++)
            vt[i] = '{1'b0, 2'd0, 1'b0, 1'b0, 30'h100, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0};
`else
        vt[12] = '{1'b0, 2'd0, 1'b0, 1'b0, 30'h000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
        vt[13] = '{1'b0, 2'd0, 1'b0, 1'b0, 30'h000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
        vt[14] = '{1'b0, 2'd0, 1'b0, 1'b0, 30'h000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
`endif

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 2'd0, 1'b0, 1'b0);
        check("idle gen_reset_n", 32'(gen_reset_n), 32'(1));

        write_tone(2'd0, 30'h100);
        write_tone(2'd1, 30'h200);
        write_tone(2'd2, 30'h300);
        write_tone(2'd3, 30'h400);

        for (int i = 0; i < 15; i++) begin
            step(vt[i].push, vt[i].sym, vt[i].go, vt[i].stop);
            check($sformatf("v%0d f_c", i),         32'(f_c),         32'(vt[i].fc));
            check($sformatf("v%0d gen_start", i),   32'(gen_start),   32'(vt[i].start));
            check($sformatf("v%0d gen_reset_n", i), 32'(gen_reset_n), 32'(vt[i].rstn));
            check($sformatf("v%0d busy", i),        32'(busy),        32'(vt[i].bsy));
            check($sformatf("v%0d underrun", i),    32'(underrun),    32'(vt[i].urun));
            check($sformatf("v%0d fifo_level", i),  32'(fifo_level),  32'(vt[i].lvl));
        end
        to_idle();

        // Test 2: nine pushes into depth 8; ninth dropped. Then test 4: stop mid-symbol.
        for (int i = 0; i < 9; i++) step(1'b1, 2'(i + 1), 1'b0, 1'b0);
        check("full level", 32'(fifo_level), 32'(8));
        check("full sym_ready", 32'(sym_ready), 32'(0));
        step(1'b0, 2'd0, 1'b1, 1'b0);
        check("first popped f_c", 32'(f_c), 32'(30'h200));
        check("after pop level", 32'(fifo_level), 32'(7));
        check("after pop sym_ready", 32'(sym_ready), 32'(1));
        step(1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check("stop level", 32'(fifo_level), 32'(0));
        check("stop f_c", 32'(f_c), 32'(0));
        check("stop rstn c1", 32'(gen_reset_n), 32'(0));
        step(1'b0, 2'd0, 1'b1, 1'b0);
        check("stop rstn c2", 32'(gen_reset_n), 32'(0));
        step(1'b0, 2'd0, 1'b0, 1'b0);
        check("stop rstn c3", 32'(gen_reset_n), 32'(1));
        check("stop busy c3", 32'(busy), 32'(0));

        // Test 5: zero length -> one clock per symbol
        cfg_sym_len = 16'd0;
        step(1'b1, 2'd1, 1'b0, 1'b0);
        step(1'b1, 2'd2, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        check("len0 s1", 32'(f_c), 32'(30'h200));
        step(1'b0, 2'd0, 1'b0, 1'b0);
        check("len0 s2", 32'(f_c), 32'(30'h300));
        step(1'b0, 2'd0, 1'b0, 1'b0);
        check("len0 s3", 32'(f_c), 32'(30'h400));
        step(1'b0, 2'd0, 1'b0, 1'b0);
        check("len0 underrun", 32'(underrun), 32'(1));
`ifdef FSK_SEQ_IDLE_TONE_EN
        check("len0 idle tone", 32'(f_c), 32'(30'h100));
        check("len0 busy", 32'(busy), 32'(1));
`else
        check("len0 shutdown f_c", 32'(f_c), 32'(0));
        check("len0 rstn", 32'(gen_reset_n), 32'(0));
`endif
        to_idle();

        // Mid-symbol tone write only shows at the next load
        cfg_sym_len = 16'd3;
        step(1'b1, 2'd1, 1'b0, 1'b0);
        step(1'b1, 2'd1, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        check("tw go", 32'(underrun), 32'(0));
        write_tone(2'd1, 30'h555);
        check("tw mid1", 32'(f_c), 32'(30'h200));
        step(1'b0, 2'd0, 1'b0, 1'b0);
        check("tw mid2", 32'(f_c), 32'(30'h200));
        step(1'b0, 2'd0, 1'b0, 1'b0);
        check("tw load", 32'(f_c), 32'(30'h555));
        to_idle();

        // Test 6: generator never becomes active
        gen_active  = 1'b0;
        cfg_sym_len = 16'd20;
        step(1'b1, 2'd2, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        check("fault gen_start", 32'(gen_start), 32'(1));
        n = 0;
        while (gen_reset_n && n < 10) begin
            step(1'b0, 2'd0, 1'b0, 1'b0);
            n++;
        end
        check("fault latency 4..5", 32'(n >= 4 && n <= 5), 32'(1));
        check("fault underrun", 32'(underrun), 32'(1));
        gen_active = 1'b1;
        to_idle();

        // Reset asserted mid-RUN
        cfg_sym_len = 16'd10;
        step(1'b1, 2'd2, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        check("prereset busy", 32'(busy), 32'(1));
        step(1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_vals("midrun reset");
        @(negedge clk);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
